// File: rtl/rx_dma_pkg.sv
// Shared RX DMA types and constants: state encoding, header size,
// chunk limits and a qword-to-byte address helper.
package rx_dma_pkg;

    localparam int HP_SIZE_LOG2_DEF = 21;
    localparam int HDR_QW = 1;
    localparam int MAX_CHUNK_QW = 512;
    localparam int CHUNK_QW_W = 10;

    typedef enum logic [2:0] {
        S_WAIT,
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_CLOSE,
        S_FREE
    } hp_state_e;

    // Byte address of a qword offset inside a page (full 64-bit carry).
    function automatic logic [63:0] qw_addr(
        input logic [63:0] base,
        input logic [31:0] qw
    );
        return base + {29'd0, qw, 3'd0};
    endfunction

endpackage

// File: rtl/rx_huge_page_sched_if.sv
// Chunk and page-close handshakes between the huge-page scheduler
// (slave) and the RX TLP write engine (master). QW_W = HP_SIZE_LOG2-2.
interface rx_huge_page_sched_if #(
    parameter int QW_W = 19
);
    import rx_dma_pkg::*;

    logic                  chunk_req;
    logic [CHUNK_QW_W-1:0] chunk_qw;
    logic                  chunk_gnt;
    logic [63:0]           chunk_addr;
    logic                  chunk_done;
    logic                  close_req;
    logic [63:0]           close_addr;
    logic [QW_W-1:0]       close_qw;
    logic                  close_ack;

    modport master (
        output chunk_req, chunk_qw, chunk_done, close_ack,
        input  chunk_gnt, chunk_addr, close_req, close_addr, close_qw
    );

    modport slave (
        input  chunk_req, chunk_qw, chunk_done, close_ack,
        output chunk_gnt, chunk_addr, close_req, close_addr, close_qw
    );

endinterface

// File: rtl/rx_hp_idle_timer.sv
// Idle cycle counter for the open huge page.
// Ports: trn_clk, reset, clr (to 0, wins), en (count up), expired.
module rx_hp_idle_timer #(
    parameter int TIMEOUT = 2048
) (
    input  logic trn_clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge trn_clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/rx_huge_page_sched.sv
// Alternates between the two driver-armed huge pages and hands out host
// write addresses for RX DMA chunks; qword 0 of each page holds a header
// written at close. Ports: trn_clk, reset, huge_page_addr/status_1/2 in,
// huge_page_free_1/2 pulses out, eng (chunk + close handshakes, slave).
module rx_huge_page_sched
    import rx_dma_pkg::*;
#(
    parameter int HP_SIZE_LOG2 = HP_SIZE_LOG2_DEF,
    parameter int IDLE_TIMEOUT = 2048
) (
    input  logic                 trn_clk,
    input  logic                 reset,
    input  logic [63:0]          huge_page_addr_1,
    input  logic [63:0]          huge_page_addr_2,
    input  logic                 huge_page_status_1,
    input  logic                 huge_page_status_2,
    output logic                 huge_page_free_1,
    output logic                 huge_page_free_2,
    rx_huge_page_sched_if.slave  eng
);

    localparam int OFF_W = HP_SIZE_LOG2 - 2;
    localparam int HP_QW = 2 ** (HP_SIZE_LOG2 - 3);
    localparam logic [OFF_W-1:0] OFF_FIRST = OFF_W'(HDR_QW);

    hp_state_e             state;
    hp_state_e             state_n;
    logic                  cur_page;
    logic [63:0]           base;
    logic [OFF_W-1:0]      offset;
    logic [CHUNK_QW_W-1:0] qw_q;
    logic [63:0]           addr_q;
    logic                  status_cur;
    logic [63:0]           addr_cur;
    logic                  fit;
    logic                  used;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_exp;

    // cur_page: 0 = page 1, 1 = page 2
    assign status_cur = cur_page ? huge_page_status_2 : huge_page_status_1;
    assign addr_cur   = cur_page ? huge_page_addr_2 : huge_page_addr_1;
    assign fit        = (32'(offset) + 32'(eng.chunk_qw)) <= 32'(HP_QW);
    assign used       = (offset != OFF_FIRST);

    // Idle time only counts on a page that already holds data.
    assign tmr_clr = (state == S_WAIT) || (state == S_GRANT);
    assign tmr_en  = (state == S_IDLE) && !eng.chunk_req && used && !tmr_exp;

    rx_hp_idle_timer #(
        .TIMEOUT (IDLE_TIMEOUT)
    ) u_timer (
        .trn_clk (trn_clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state    <= S_WAIT;
            cur_page <= 1'b0;
            base     <= '0;
            offset   <= OFF_FIRST;
            qw_q     <= '0;
            addr_q   <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                S_WAIT: begin
                    if (status_cur) begin
                        base   <= addr_cur;
                        offset <= OFF_FIRST;
                    end
                end
                S_IDLE: begin
                    // Address and length latched at the grant decision.
                    if (eng.chunk_req && fit) begin
                        addr_q <= qw_addr(base, 32'(offset));
                        qw_q   <= eng.chunk_qw;
                    end
                end
                S_GRANT: offset <= offset + OFF_W'(qw_q);
                S_FREE:  cur_page <= ~cur_page;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n          = state;
        eng.chunk_gnt    = 1'b0;
        eng.close_req    = 1'b0;
        eng.close_addr   = '0;
        eng.close_qw     = '0;
        huge_page_free_1 = 1'b0;
        huge_page_free_2 = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (status_cur) state_n = S_IDLE;
            end
            S_IDLE: begin
                // A request always wins over a same-cycle timeout.
                if (eng.chunk_req) begin
                    state_n = fit ? S_GRANT : S_CLOSE;
                end else if (used && tmr_exp) begin
                    state_n = S_CLOSE;
                end
            end
            S_GRANT: begin
                eng.chunk_gnt = 1'b1;
                state_n       = S_BUSY;
            end
            S_BUSY: begin
                if (eng.chunk_done) state_n = S_IDLE;
            end
            S_CLOSE: begin
                eng.close_req  = 1'b1;
                eng.close_addr = base;
                eng.close_qw   = offset - OFF_FIRST;
                if (eng.close_ack) state_n = S_FREE;
            end
            S_FREE: begin
                huge_page_free_1 = !cur_page;
                huge_page_free_2 = cur_page;
                state_n          = S_WAIT;
            end
            default: state_n = S_WAIT;
        endcase
    end

    assign eng.chunk_addr = addr_q;

endmodule

// File: tb/tb_rx_huge_page_sched.sv
// Directed bench for rx_huge_page_sched: table of chunk requests
// across alternating pages plus timeout, stall, carry and reset cases.
module tb_rx_huge_page_sched;
    import rx_dma_pkg::*;

    localparam int HPL = 12;
    localparam int TO = 2048;
    localparam int QW_W = HPL - 2;
    localparam logic [63:0] A1 = 64'h1_0000_0000;
    localparam logic [63:0] A2 = 64'h2_0000_0000;

    logic        trn_clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] a1 = '0;
    logic [63:0] a2 = '0;
    logic        s1 = 1'b0;
    logic        s2 = 1'b0;
    logic        f1;
    logic        f2;

    int n_tests = 0;
    int n_fail = 0;

    rx_huge_page_sched_if #(.QW_W(QW_W)) eng ();

    rx_huge_page_sched #(
        .HP_SIZE_LOG2 (HPL),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .trn_clk            (trn_clk),
        .reset              (reset),
        .huge_page_addr_1   (a1),
        .huge_page_addr_2   (a2),
        .huge_page_status_1 (s1),
        .huge_page_status_2 (s2),
        .huge_page_free_1   (f1),
        .huge_page_free_2   (f2),
        .eng                (eng)
    );

    always #5 trn_clk = ~trn_clk;

    always @(posedge trn_clk) begin
        if (!reset && eng.chunk_req)
            assert (eng.chunk_qw >= 1 && 32'(eng.chunk_qw) <= MAX_CHUNK_QW)
            else $error("illegal chunk_qw %0d", eng.chunk_qw);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [9:0]  qw;
        bit          close;
        logic [63:0] close_addr;
        logic [63:0] close_qw;
        logic [1:0]  free;
        logic [63:0] addr;
    } vec_t;

    vec_t tbl [8];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        eng.chunk_req = 1'b0;
        eng.chunk_qw = 10'd1;
        eng.chunk_done = 1'b0;
        eng.close_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return {eng.chunk_gnt, eng.close_req, f1, f2}
             | eng.chunk_addr | eng.close_addr | 64'(eng.close_qw);
    endfunction

    task automatic done_pulse();
        tick();
        eng.chunk_done = 1'b1;
        tick();
        eng.chunk_done = 1'b0;
    endtask

    task automatic req_chunk(
        input  logic [9:0]  qw,
        input  int          max_cyc,
        input  bit          ack,
        input  bit          keep,
        output bit          got_gnt,
        output logic [63:0] addr,
        output bit          got_close,
        output logic [63:0] caddr,
        output logic [63:0] cqw,
        output logic [1:0]  fv
    );
        got_gnt = 0;
        got_close = 0;
        addr = '0;
        caddr = '0;
        cqw = '0;
        fv = '0;
        eng.chunk_qw = qw;
        eng.chunk_req = 1'b1;
        for (int i = 0; i < max_cyc && !got_gnt; i++) begin
            tick();
            if (eng.chunk_gnt) begin
                got_gnt = 1;
                addr = eng.chunk_addr;
            end else if (eng.close_req && !got_close) begin
                got_close = 1;
                caddr = eng.close_addr;
                cqw = 64'(eng.close_qw);
                if (ack) begin
                    eng.close_ack = 1'b1;
                    tick();
                    eng.close_ack = 1'b0;
                    fv = {f2, f1};
                end
            end
        end
        if (got_gnt || !keep) eng.chunk_req = 1'b0;
    endtask

    initial begin
        bit          g;
        bit          c;
        bit          seen;
        logic [63:0] ad;
        logic [63:0] ca;
        logic [63:0] cq;
        logic [1:0]  fv;
        int          n;

        tbl[0] = '{10'd8,   1'b0, 64'd0, 64'd0,   2'b00, A1 + 64'h8};
        tbl[1] = '{10'd4,   1'b0, 64'd0, 64'd0,   2'b00, A1 + 64'h48};
        tbl[2] = '{10'd498, 1'b0, 64'd0, 64'd0,   2'b00, A1 + 64'h68};
        tbl[3] = '{10'd1,   1'b0, 64'd0, 64'd0,   2'b00, A1 + 64'hFF8};
        tbl[4] = '{10'd255, 1'b1, A1,    64'd511, 2'b01, A2 + 64'h8};
        tbl[5] = '{10'd255, 1'b0, 64'd0, 64'd0,   2'b00, A2 + 64'h800};
        tbl[6] = '{10'd8,   1'b1, A2,    64'd510, 2'b10, A1 + 64'h8};
        tbl[7] = '{10'd504, 1'b1, A1,    64'd8,   2'b01, A2 + 64'h8};

        // Reset state, nothing armed: idle outputs and a stalled request.
        do_reset();
        check("reset_outs", outs(), 64'd0);
        req_chunk(10'd8, 20, 1, 0, g, ad, c, ca, cq, fv);
        check("unarmed_no_gnt", {62'd0, g, c}, 64'd0);

        // Table: alternating pages, exact fill, overflow close.
        do_reset();
        a1 = A1;
        a2 = A2;
        s1 = 1'b1;
        s2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_chunk(tbl[i].qw, 20, 1, 0, g, ad, c, ca, cq, fv);
            check($sformatf("row%0d_gnt", i), 64'(g), 64'd1);
            check($sformatf("row%0d_addr", i), ad, tbl[i].addr);
            check($sformatf("row%0d_close", i), 64'(c), 64'(tbl[i].close));
            if (tbl[i].close) begin
                check($sformatf("row%0d_caddr", i), ca, tbl[i].close_addr);
                check($sformatf("row%0d_cqw", i), cq, tbl[i].close_qw);
                check($sformatf("row%0d_free", i), 64'(fv), 64'(tbl[i].free));
            end
            done_pulse();
        end

        // Idle timeout on a used page; empty page never times out.
        do_reset();
        req_chunk(10'd8, 10, 1, 0, g, ad, c, ca, cq, fv);
        check("t3_gnt_addr", ad, A1 + 64'h8);
        done_pulse();
        n = 0;
        while (!eng.close_req && n < TO + 100) begin
            tick();
            n++;
        end
        check("t3_timeout_cycles", 64'(n), 64'(TO));
        check("t3_close_qw", 64'(eng.close_qw), 64'd8);
        check("t3_close_addr", eng.close_addr, A1);
        eng.close_ack = 1'b1;
        tick();
        eng.close_ack = 1'b0;
        check("t3_free1", {62'd0, f2, f1}, 64'd1);
        tick();
        check("t3_free1_once", {62'd0, f2, f1}, 64'd0);
        seen = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (eng.close_req) seen = 1;
        end
        check("t3_empty_no_close", 64'(seen), 64'd0);

        // Page 2 not armed: request stalls until it is.
        do_reset();
        s2 = 1'b0;
        req_chunk(10'd8, 10, 1, 0, g, ad, c, ca, cq, fv);
        check("t4_gnt_addr", ad, A1 + 64'h8);
        s1 = 1'b0;
        done_pulse();
        req_chunk(10'd504, 40, 1, 1, g, ad, c, ca, cq, fv);
        check("t4_close_qw", cq, 64'd8);
        check("t4_free", 64'(fv), 64'd1);
        check("t4_stall_no_gnt", 64'(g), 64'd0);
        s2 = 1'b1;
        req_chunk(10'd504, 3, 1, 0, g, ad, c, ca, cq, fv);
        check("t4_late_gnt", 64'(g), 64'd1);
        check("t4_late_addr", ad, A2 + 64'h8);
        done_pulse();

        // 32-bit carry in the chunk address.
        do_reset();
        a1 = 64'h0000_0000_FFFF_FFF8;
        s1 = 1'b1;
        req_chunk(10'd1, 10, 1, 0, g, ad, c, ca, cq, fv);
        check("t5_carry_addr", ad, 64'h0000_0001_0000_0000);
        done_pulse();

        // Reset in S_BUSY and in S_CLOSE.
        do_reset();
        a1 = A1;
        req_chunk(10'd8, 10, 1, 0, g, ad, c, ca, cq, fv);
        tick();
        reset = 1'b1;
        tick();
        check("t6_busy_rst_outs", outs(), 64'd0);
        reset = 1'b0;
        req_chunk(10'd8, 10, 1, 0, g, ad, c, ca, cq, fv);
        check("t6_busy_resume", ad, A1 + 64'h8);
        done_pulse();
        req_chunk(10'd504, 5, 0, 1, g, ad, c, ca, cq, fv);
        check("t6_close_seen", {62'd0, g, c}, 64'd1);
        reset = 1'b1;
        eng.chunk_req = 1'b0;
        tick();
        check("t6_close_rst_outs", outs(), 64'd0);
        reset = 1'b0;
        req_chunk(10'd8, 10, 1, 0, g, ad, c, ca, cq, fv);
        check("t6_close_resume", ad, A1 + 64'h8);
        done_pulse();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
